// File: rtl/audio_cond_pkg.sv
// Shared types, constants and saturation helpers for the audio sample conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package audio_cond_pkg;

    // Volume ramp controller states
    typedef enum logic {
        HOLD = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

    // Clip indicator hold time in sample strobes (~100 ms at 48 kHz)
    localparam int CLIP_HOLD  = 4800;
    localparam int CLIP_CNT_W = 13;

    // Largest / smallest value representable in a w-bit signed word
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/audio_sample_conditioner_if.sv
// Bundles the sample/volume inputs and conditioned outputs of the audio conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; samples are presented every clk and outputs are level/strobe signals.
// Signals: audio_in (CHANNELS*IN_W, ch0 in LSBs), volume (VOL_W), audio_out (CHANNELS*OUT_W),
//          audio_clk, sample_stb, ramp_busy, clip (CHANNELS, only with AUDIO_CLIP_DETECT_EN).
// master = audio source / consumer side, slave = the conditioner.
interface audio_sample_conditioner_if #(
    parameter int CHANNELS = 2,
    parameter int IN_W     = 18,
    parameter int OUT_W    = 16,
    parameter int VOL_W    = 3
);
    logic [CHANNELS*IN_W-1:0]  audio_in;
    logic [VOL_W-1:0]          volume;
    logic [CHANNELS*OUT_W-1:0] audio_out;
    logic                      audio_clk;
    logic                      sample_stb;
    logic                      ramp_busy;
`ifdef AUDIO_CLIP_DETECT_EN
    logic [CHANNELS-1:0]       clip;

    modport master (
        output audio_in, volume,
        input  audio_out, audio_clk, sample_stb, ramp_busy, clip
    );
    modport slave (
        input  audio_in, volume,
        output audio_out, audio_clk, sample_stb, ramp_busy, clip
    );
`else
    modport master (
        output audio_in, volume,
        input  audio_out, audio_clk, sample_stb, ramp_busy
    );
    modport slave (
        input  audio_in, volume,
        output audio_out, audio_clk, sample_stb, ramp_busy
    );
`endif
endinterface

// File: rtl/audio_rate_gen.sv
// Fractional clock divider producing the audio sample clock and a one-clk strobe on its rising edge.
// Latency: outputs registered; audio_clk and sample_stb change on the same clk edge.
// Backpressure: none; free-running.
// Ports: clk, resetn (async active-low), audio_clk_o (~50% duty at SAMPLE_RATE), sample_stb_o.
module audio_rate_gen #(
    parameter int CLK_HZ      = 32000000,
    parameter int SAMPLE_RATE = 48000,
    parameter int ACC_W       = 27
) (
    input  logic clk,
    input  logic resetn,
    output logic audio_clk_o,
    output logic sample_stb_o
);
    // Two toggles per audio period, so the accumulator advances by twice the sample rate
    localparam logic [ACC_W-1:0] STEP = ACC_W'(2 * SAMPLE_RATE);
    localparam logic [ACC_W-1:0] WRAP = ACC_W'(CLK_HZ);

    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic             aclk_q, aclk_d;
    logic             stb_q, stb_d;

    // Remainder is kept on wrap, so the long-run toggle rate is exact
    always_comb begin
        sum    = acc_q + STEP;
        acc_d  = sum;
        aclk_d = aclk_q;
        stb_d  = 1'b0;
        if (sum >= WRAP) begin
            acc_d  = sum - WRAP;
            aclk_d = ~aclk_q;
            stb_d  = ~aclk_q;   // strobe only on the 0->1 toggle
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q  <= '0;
            aclk_q <= 1'b0;
            stb_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            aclk_q <= aclk_d;
            stb_q  <= stb_d;
        end
    end

    assign audio_clk_o  = aclk_q;
    assign sample_stb_o = stb_q;

endmodule

// File: rtl/audio_sample_conditioner.sv
// N-channel audio front end: rescale+saturate to OUT_W, ramped 6 dB-step volume, sample-rate hold.
// Latency: audio_in to S3 is 3 clks; audio_out latches S3 on sample_stb and holds between strobes.
// Backpressure: none; input sampled every clk, output is a held level qualified by sample_stb.
// Ports: clk, resetn (async active-low), bus (audio_sample_conditioner_if.slave).
// Optional: define AUDIO_CLIP_DETECT_EN to add per-channel clip indicators (bus.clip).
module audio_sample_conditioner
    import audio_cond_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int IN_W        = 18,
    parameter int OUT_W       = 16,
    parameter int BOOST       = 1,
    parameter int VOL_W       = 3,
    parameter int CLK_HZ      = 32000000,
    parameter int SAMPLE_RATE = 48000,
    parameter int ACC_W       = 27
) (
    input  logic                        clk,
    input  logic                        resetn,
    audio_sample_conditioner_if.slave   bus
);
    localparam int               XW   = OUT_W + BOOST;   // S1 width before saturation
    localparam int               WW   = IN_W + BOOST;    // width after boost shift
    localparam logic [VOL_W-1:0] VMAX = '1;

    logic stb;
    logic aclk;

    audio_rate_gen #(
        .CLK_HZ      (CLK_HZ),
        .SAMPLE_RATE (SAMPLE_RATE),
        .ACC_W       (ACC_W)
    ) u_rate_gen (
        .clk          (clk),
        .resetn       (resetn),
        .audio_clk_o  (aclk),
        .sample_stb_o (stb)
    );

    // ---------------- volume ramp ----------------
    ramp_state_t      state_q, state_d;
    logic [VOL_W-1:0] cur_vol_q, cur_vol_d, step_vol;

    always_comb begin
        state_d   = state_q;
        cur_vol_d = cur_vol_q;
        step_vol  = (bus.volume > cur_vol_q) ? cur_vol_q + 1'b1 : cur_vol_q - 1'b1;
        case (state_q)
            HOLD: begin
                if (bus.volume != cur_vol_q) state_d = RAMP;
            end
            RAMP: begin
                // Target may move at any time; direction follows the current target
                if (bus.volume == cur_vol_q) begin
                    state_d = HOLD;
                end else if (stb) begin
                    cur_vol_d = step_vol;
                    if (step_vol == bus.volume) state_d = HOLD;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= HOLD;
            cur_vol_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_vol_q <= cur_vol_d;
        end
    end

    // ---------------- per-channel datapath ----------------
    logic [CHANNELS*OUT_W-1:0] out_w;
`ifdef AUDIO_CLIP_DETECT_EN
    logic [CHANNELS-1:0]       clip_w;
`endif

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic signed [IN_W-1:0]  in_s;
        logic signed [XW-1:0]    s1_d, s1_q;
        logic signed [OUT_W-1:0] s2_d, s2_q, s3_d, s3_q, out_q;

        assign in_s = bus.audio_in[ch*IN_W +: IN_W];

        // Boost then drop the low bits; the truncating cast keeps the arithmetic-shifted result
        assign s1_d = XW'((WW'(in_s) <<< BOOST) >>> (IN_W - OUT_W));

        always_comb begin
            s2_d = s1_q[OUT_W-1:0];
            if (int'(s1_q) > sat_max(OUT_W)) begin
                s2_d = OUT_W'(sat_max(OUT_W));
            end else if (int'(s1_q) < sat_min(OUT_W)) begin
                s2_d = OUT_W'(sat_min(OUT_W));
            end
        end

        // Gain 0 forces a true zero so negative samples do not leave a -1 residue
        always_comb begin
            s3_d = '0;
            if (cur_vol_q != '0) begin
                s3_d = s2_q >>> (VMAX - cur_vol_q);
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                s1_q  <= '0;
                s2_q  <= '0;
                s3_q  <= '0;
                out_q <= '0;
            end else begin
                s1_q <= s1_d;
                s2_q <= s2_d;
                s3_q <= s3_d;
                if (stb) out_q <= s3_q;
            end
        end

        assign out_w[ch*OUT_W +: OUT_W] = out_q;

`ifdef AUDIO_CLIP_DETECT_EN
        logic                  sat;
        logic [CLIP_CNT_W-1:0] clip_cnt_q, clip_cnt_d;

        assign sat = (int'(s1_q) > sat_max(OUT_W)) || (int'(s1_q) < sat_min(OUT_W));

        // Every saturation reloads the hold window; it then drains one step per strobe
        always_comb begin
            clip_cnt_d = clip_cnt_q;
            if (sat) begin
                clip_cnt_d = CLIP_CNT_W'(CLIP_HOLD);
            end else if (stb && (clip_cnt_q != '0)) begin
                clip_cnt_d = clip_cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                clip_cnt_q <= '0;
            end else begin
                clip_cnt_q <= clip_cnt_d;
            end
        end

        assign clip_w[ch] = (clip_cnt_q != '0);
`endif
    end

    assign bus.audio_out  = out_w;
    assign bus.audio_clk  = aclk;
    assign bus.sample_stb = stb;
    assign bus.ramp_busy  = (state_q == RAMP) | (bus.volume != cur_vol_q);
`ifdef AUDIO_CLIP_DETECT_EN
    assign bus.clip       = clip_w;
`endif

endmodule

// File: tb/tb_audio_sample_conditioner.sv
// Randomized self-checking bench for audio_sample_conditioner against an arithmetic reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_audio_sample_conditioner;
    localparam int CH     = 2;
    localparam int IW     = 18;
    localparam int OW     = 16;
    localparam int VW     = 3;
    localparam int BOOSTV = 1;
    localparam int VMAXV  = 7;
    localparam longint CLKHZ = 32000000;
    localparam longint SRATE = 48000;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    audio_sample_conditioner_if #(.CHANNELS(CH), .IN_W(IW), .OUT_W(OW), .VOL_W(VW)) bus();

    audio_sample_conditioner dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int gain_m;
    int in_m [CH];
    bit clip_m [CH];

    // Value after boost, width reduction (floor) and saturation to OW bits
    function automatic int scale(input int x);
        int v;
        v = (x * (1 << BOOSTV)) >>> (IW - OW);
        if (v > (1 << (OW - 1)) - 1) v = (1 << (OW - 1)) - 1;
        else if (v < -(1 << (OW - 1))) v = -(1 << (OW - 1));
        return v;
    endfunction

    function automatic bit will_sat(input int x);
        int v;
        v = (x * (1 << BOOSTV)) >>> (IW - OW);
        return (v > (1 << (OW - 1)) - 1) || (v < -(1 << (OW - 1)));
    endfunction

    // Each volume step is 6 dB, i.e. one halving; floor division for negatives
    function automatic int ref_out(input int x, input int g);
        if (g == 0) return 0;
        return scale(x) >>> (VMAXV - g);
    endfunction

    task automatic apply(input int c, input int x);
        in_m[c] = x;
        bus.audio_in[c*IW +: IW] = IW'(x);
        if (will_sat(x)) clip_m[c] = 1'b1;
    endtask

    function automatic int rand_sample();
        case ($urandom_range(0, 5))
            0:       return 256;
            1:       return 131071;
            2:       return -131072;
            3:       return -1;
            default: return int'($urandom_range(0, 262143)) - 131072;
        endcase
    endfunction

    task automatic wait_stb();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (bus.sample_stb) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("stb_timeout", 0, 1);
    endtask

    // Wait for a strobe, then check the latched samples and the gain step that accompanies it
    task automatic strobe_check(input string tag);
        wait_stb();
        chk({tag, "_busy_pre"}, bus.ramp_busy, (gain_m != int'(bus.volume)));
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("%s_out_ch%0d", tag, c),
                int'($signed(bus.audio_out[c*OW +: OW])), ref_out(in_m[c], gain_m));
`ifdef AUDIO_CLIP_DETECT_EN
            chk($sformatf("%s_clip_ch%0d", tag, c), bus.clip[c], clip_m[c]);
`endif
        end
        if (gain_m < int'(bus.volume)) gain_m++;
        else if (gain_m > int'(bus.volume)) gain_m--;
        chk({tag, "_busy"}, bus.ramp_busy, (gain_m != int'(bus.volume)));
    endtask

    // ---------------- rate monitor ----------------
    // Rising edge k lands ceil((2k-1)*CLK_HZ/(2*SAMPLE_RATE)) clks after reset release
    int n_edge = 0;
    int k_rise = 0;
    int first_rise = 0;
    int stray = 0;
    bit aclk_prev = 1'b0;

    always @(negedge clk) begin
        if (!resetn) begin
            n_edge    = 0;
            k_rise    = 0;
            aclk_prev = 1'b0;
            if (bus.sample_stb) stray++;
        end else begin
            n_edge++;
            if (bus.audio_clk && !aclk_prev) begin
                longint num;
                k_rise++;
                num = longint'(2 * k_rise - 1) * CLKHZ;
                chk("rise_edge", n_edge, (num + 2 * SRATE - 1) / (2 * SRATE));
                chk("stb_on_rise", bus.sample_stb, 1);
                if (k_rise == 1) first_rise = n_edge;
                if (k_rise == 49) chk("clks_per_48_strobes", n_edge - first_rise, 32000);
            end else if (bus.sample_stb) begin
                stray++;
            end
            aclk_prev = bus.audio_clk;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        resetn     = 1'b0;
        bus.volume = 3'd7;
        bus.audio_in = '0;
        gain_m = 0;
        for (int c = 0; c < CH; c++) begin
            in_m[c]   = 0;
            clip_m[c] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_out", bus.audio_out, 0);
        chk("rst_aclk", bus.audio_clk, 0);
        chk("rst_stb", bus.sample_stb, 0);
        chk("rst_busy", bus.ramp_busy, 1);
        apply(0, 256);
        apply(1, rand_sample());
        #2 resetn = 1'b1;

        // Ramp from mute to unity, then one strobe at full gain
        for (int i = 0; i < 8; i++) strobe_check("ramp");
        chk("ramp_gain", gain_m, 7);

        // Saturation both directions
        apply(0, 131071);
        apply(1, -131072);
        for (int i = 0; i < 2; i++) strobe_check("sat_a");
        apply(0, -131072);
        apply(1, 131071);
        for (int i = 0; i < 2; i++) strobe_check("sat_b");

        // Down-ramp, retarget upward mid-ramp, then mute on negative input
        apply(0, -1);
        apply(1, -(int'($urandom_range(1, 131072))));
        bus.volume = 3'd0;
        for (int i = 0; i < 3; i++) strobe_check("down");
        bus.volume = 3'd5;
        for (int i = 0; i < 3; i++) strobe_check("retarget");
        chk("retarget_gain", gain_m, 5);
        bus.volume = 3'd0;
        for (int i = 0; i < 6; i++) strobe_check("mute");

        // Random traffic
        for (int i = 0; i < 34; i++) begin
            for (int c = 0; c < CH; c++) apply(c, rand_sample());
            if ($urandom_range(0, 3) == 0) bus.volume = VW'($urandom_range(0, 7));
            strobe_check("rand");
        end

        // Bring gain to 1, start an up-ramp, and reset partway through it
        apply(0, 65535);
        apply(1, -65536);
        bus.volume = 3'd1;
        for (int i = 0; i < 8; i++) if (gain_m != 1) strobe_check("pre_rst");
        bus.volume = 3'd7;
        for (int i = 0; i < 3; i++) strobe_check("mid_ramp");
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_out", bus.audio_out, 0);
        chk("arst_aclk", bus.audio_clk, 0);
        chk("arst_stb", bus.sample_stb, 0);
        chk("arst_busy", bus.ramp_busy, 1);
        gain_m = 0;
        for (int c = 0; c < CH; c++) clip_m[c] = will_sat(in_m[c]);
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;

        // Ramps up again from mute after reset
        for (int i = 0; i < 8; i++) strobe_check("post_rst");
        chk("post_rst_gain", gain_m, 7);

        chk("stray_stb", stray, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
